// File: rtl/array_pkg.sv
// Shared constants and FSM state type for the systolic-array input feeder.
package array_pkg;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned N          = 4;
   localparam int unsigned FEED_LEN   = 3*N-2;
   localparam int unsigned TILE_BYTES = 2*N*N;

   typedef enum logic [2:0] {LOAD, ARMED, CLEAR, FEED, DONE} state_t;
endpackage

// File: rtl/array_feeder_tile_buffer.sv
// Tile store for one A and one B tile: single write port, eight combinational read ports.
module tile_buffer
   import array_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = array_pkg::DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [4:0]              wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [39:0]             rd_addr,
   output logic [8*DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem [TILE_BYTES];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_comb begin
      for (int unsigned p = 0; p < 8; p++) begin
         rd_data[p*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[p*5 +: 5]];
      end
   end
endmodule

// File: rtl/array_feeder.sv
// Input scheduler for the 4x4 systolic MAC array: buffers A/B tiles, clears, then feeds with skew.
// Optional ARRAY_FEEDER_PERF_EN adds the perf_cycles job-cycle counter.
module array_feeder
   import array_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = array_pkg::DATA_WIDTH,
   parameter int unsigned N          = array_pkg::N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  arr_rst_n,
   output logic                  arr_we,
   output logic [DATA_WIDTH-1:0] a_in0,
   output logic [DATA_WIDTH-1:0] a_in1,
   output logic [DATA_WIDTH-1:0] a_in2,
   output logic [DATA_WIDTH-1:0] a_in3,
   output logic [DATA_WIDTH-1:0] b_in0,
   output logic [DATA_WIDTH-1:0] b_in1,
   output logic [DATA_WIDTH-1:0] b_in2,
   output logic [DATA_WIDTH-1:0] b_in3
`ifdef ARRAY_FEEDER_PERF_EN
   ,
   output logic [15:0]           perf_cycles
`endif
);
   localparam logic [3:0] FEED_LAST = 4'(3*N-3);

   state_t                  state;
   logic [4:0]              cnt;
   logic [3:0]              t;
   logic [3:0]              tn;
   logic [3:0]              lag [4];
   logic [3:0]              lane_ok;
   logic                    feed_next;
   logic                    buf_we;
   logic [39:0]             rd_addr;
   logic [8*DATA_WIDTH-1:0] rd_data;

   tile_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk     (clk),
      .we      (buf_we),
      .wr_addr (cnt),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign buf_we = (state == LOAD) && in_valid && in_ready;

   // Outputs are registered, so the read side looks up the step that will be shown next cycle.
   always_comb begin
      feed_next = (state == CLEAR) || ((state == FEED) && (t != FEED_LAST));
      tn        = (state == FEED) ? t + 4'd1 : 4'd0;
      rd_addr   = '0;
      lane_ok   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         lag[i]     = tn - 4'(i);
         lane_ok[i] = (tn >= 4'(i)) && (lag[i] <= 4'd3);
         rd_addr[i*5 +: 5]     = {1'b0, 2'(i), lag[i][1:0]};
         rd_addr[(i+4)*5 +: 5] = {1'b1, lag[i][1:0], 2'(i)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         cnt       <= '0;
         t         <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         arr_rst_n <= 1'b0;
         arr_we    <= 1'b0;
         a_in0 <= '0; a_in1 <= '0; a_in2 <= '0; a_in3 <= '0;
         b_in0 <= '0; b_in1 <= '0; b_in2 <= '0; b_in3 <= '0;
      end else begin
         done      <= 1'b0;
         arr_rst_n <= 1'b1;
         arr_we    <= feed_next;
         case (state)
            LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     state    <= ARMED;
                     in_ready <= 1'b0;
                  end
               end
            end
            ARMED: begin
               if (start) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  arr_rst_n <= 1'b0;
               end
            end
            CLEAR: begin
               state <= FEED;
               t     <= '0;
            end
            FEED: begin
               if (t == FEED_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  t <= tn;
               end
            end
            DONE: begin
               state    <= LOAD;
               cnt      <= '0;
               t        <= '0;
               in_ready <= 1'b1;
            end
            default: state <= LOAD;
         endcase
         a_in0 <= (feed_next && lane_ok[0]) ? rd_data[0*DATA_WIDTH +: DATA_WIDTH] : '0;
         a_in1 <= (feed_next && lane_ok[1]) ? rd_data[1*DATA_WIDTH +: DATA_WIDTH] : '0;
         a_in2 <= (feed_next && lane_ok[2]) ? rd_data[2*DATA_WIDTH +: DATA_WIDTH] : '0;
         a_in3 <= (feed_next && lane_ok[3]) ? rd_data[3*DATA_WIDTH +: DATA_WIDTH] : '0;
         b_in0 <= (feed_next && lane_ok[0]) ? rd_data[4*DATA_WIDTH +: DATA_WIDTH] : '0;
         b_in1 <= (feed_next && lane_ok[1]) ? rd_data[5*DATA_WIDTH +: DATA_WIDTH] : '0;
         b_in2 <= (feed_next && lane_ok[2]) ? rd_data[6*DATA_WIDTH +: DATA_WIDTH] : '0;
         b_in3 <= (feed_next && lane_ok[3]) ? rd_data[7*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
   end

`ifdef ARRAY_FEEDER_PERF_EN
   // Job span runs from the accepted start cycle through the last feed cycle: 12 per job.
   logic job_active;
   assign job_active = ((state == ARMED) && start) || (state == CLEAR) || (state == FEED);

   always_ff @(posedge clk) begin
      if (rst)                                   perf_cycles <= '0;
      else if (job_active && perf_cycles != '1)  perf_cycles <= perf_cycles + 16'd1;
   end
`endif
endmodule

// File: tb/tb_array_feeder.sv
// Self-checking bench for array_feeder: table of jobs plus hand-written reset/start corner sequences.
module tb_array_feeder;
   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, start, busy, done, arr_rst_n, arr_we;
   logic [7:0] in_data;
   logic [7:0] a_in0, a_in1, a_in2, a_in3, b_in0, b_in1, b_in2, b_in3;
`ifdef ARRAY_FEEDER_PERF_EN
   logic [15:0] perf_cycles;
`endif

   array_feeder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .start(start), .busy(busy), .done(done), .arr_rst_n(arr_rst_n), .arr_we(arr_we),
      .a_in0(a_in0), .a_in1(a_in1), .a_in2(a_in2), .a_in3(a_in3),
      .b_in0(b_in0), .b_in1(b_in1), .b_in2(b_in2), .b_in3(b_in3)
`ifdef ARRAY_FEEDER_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int a_kind;
      int b_kind;
      int gap;
      int start_in_load;
      int start_in_feed;
      int c_exp[16];
   } job_t;

   int         errors = 0;
   int         checks = 0;
   int         done_seen = 0;
   logic [7:0] A [16];
   logic [7:0] B [16];
   logic [7:0] ah [4][10];
   logic [7:0] bh [4][10];
   int         cres [16];
   job_t       jobs [5];

   always @(negedge clk) if (done === 1'b1) done_seen++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] elem(input int kind, input int idx);
      int r = idx / 4;
      int c = idx % 4;
      case (kind)
         0:       return 8'(idx + 1);
         1:       return (r == c) ? 8'd1 : 8'd0;
         2:       return 8'd1;
         3:       return 8'd2;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [63:0] ab_now();
      return {a_in3, a_in2, a_in1, a_in0, b_in3, b_in2, b_in1, b_in0};
   endfunction

   function automatic logic [63:0] ab_exp(input int t);
      logic [7:0] ea [4];
      logic [7:0] eb [4];
      for (int i = 0; i < 4; i++) begin
         ea[i] = (t >= i && t - i <= 3) ? A[i*4 + (t-i)] : 8'd0;
         eb[i] = (t >= i && t - i <= 3) ? B[(t-i)*4 + i] : 8'd0;
      end
      return {ea[3], ea[2], ea[1], ea[0], eb[3], eb[2], eb[1], eb[0]};
   endfunction

   task automatic load_tile(input int ka, input int kb, input int gap, input int start_pulse);
      int idx = 0;
      int budget = 0;
      logic xfer;
      for (int i = 0; i < 16; i++) begin
         A[i] = elem(ka, i);
         B[i] = elem(kb, i);
      end
      while (idx < 32 && budget < 2000) begin
         in_valid = (gap != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = (idx < 16) ? A[idx] : B[idx-16];
         start    = (start_pulse != 0 && idx == 5) ? 1'b1 : 1'b0;
         xfer     = in_valid && in_ready;
         tick();
         if (xfer) idx++;
         budget++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("load_complete", 64'(idx), 64'd32);
      chk("in_ready_low_armed", 64'(in_ready), 64'd0);
   endtask

   // Returns after the first LOAD cycle following DONE, or just after reset when rst_at >= 0.
   task automatic run_job(input int start_in_feed, input int rst_at);
      int seen0 = done_seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("clear_cycle", {60'd0, arr_rst_n, arr_we, busy, done}, {60'd0, 4'b0010});
      for (int t = 0; t < 10; t++) begin
         tick();
         start = (start_in_feed != 0 && t == 3) ? 1'b1 : 1'b0;
         chk("feed_ctrl", {60'd0, arr_rst_n, arr_we, busy, done}, {60'd0, 4'b1110});
         chk("feed_skew", ab_now(), ab_exp(t));
         for (int i = 0; i < 4; i++) begin
            ah[i][t] = (i == 0) ? a_in0 : (i == 1) ? a_in1 : (i == 2) ? a_in2 : a_in3;
            bh[i][t] = (i == 0) ? b_in0 : (i == 1) ? b_in1 : (i == 2) ? b_in2 : b_in3;
         end
         if (t == rst_at) begin
            start = 1'b0;
            rst   = 1'b1;
            tick();
            rst   = 1'b0;
            chk("midfeed_rst_out", {55'd0, arr_rst_n, arr_we, busy, done, in_ready, 4'd0},
                {55'd0, 5'b00000, 4'd0});
            chk("midfeed_rst_ab", ab_now(), 64'd0);
            tick();
            chk("after_rst_load", {62'd0, in_ready, done}, {62'd0, 2'b10});
            chk("no_done_on_rst", 64'(done_seen - seen0), 64'd0);
            return;
         end
      end
      start = 1'b0;
      tick();
      chk("done_cycle", {60'd0, arr_rst_n, arr_we, busy, done}, {60'd0, 4'b1001});
      chk("done_ab_zero", ab_now(), 64'd0);
      tick();
      chk("back_to_load", {62'd0, in_ready, done}, {62'd0, 2'b10});
      chk("one_done", 64'(done_seen - seen0), 64'd1);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            cres[i*4+j] = 0;
            for (int t = 0; t < 10; t++)
               if (t >= i && t >= j) cres[i*4+j] += int'(ah[i][t-j]) * int'(bh[j][t-i]);
         end
   endtask

   task automatic full_job(input job_t jb, input string tag);
      load_tile(jb.a_kind, jb.b_kind, jb.gap, jb.start_in_load);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("armed_wait", {62'd0, busy, arr_rst_n}, {62'd0, 2'b01});
      end
      run_job(jb.start_in_feed, -1);
      for (int e = 0; e < 16; e++) begin
         checks++;
         if (cres[e] != jb.c_exp[e]) begin
            errors++;
            $display("FAIL %s_c%0d: got %0d expected %0d", tag, e, cres[e], jb.c_exp[e]);
         end
      end
   endtask

   initial begin
      jobs[0] = '{0, 1, 0, 0, 0, '{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16}};
      jobs[1] = '{2, 3, 0, 0, 0, '{8,8,8,8, 8,8,8,8, 8,8,8,8, 8,8,8,8}};
      jobs[2] = '{0, 1, 1, 0, 0, '{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16}};
      jobs[3] = '{2, 0, 0, 1, 1, '{28,32,36,40, 28,32,36,40, 28,32,36,40, 28,32,36,40}};
      jobs[4] = '{4, 1, 1, 0, 0, '{255,255,255,255, 255,255,255,255,
                                   255,255,255,255, 255,255,255,255}};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0;
      tick(); tick();
      chk("reset_ctrl", {58'd0, in_ready, busy, done, arr_rst_n, arr_we, 1'b0}, 64'd0);
      chk("reset_ab", ab_now(), 64'd0);
      rst = 1'b0;
      tick();
      chk("in_ready_rises", {62'd0, in_ready, arr_rst_n}, {62'd0, 2'b11});

      for (int j = 0; j < 5; j++) full_job(jobs[j], $sformatf("job%0d", j));

      // Reset in the middle of FEED, then a fresh job must still be correct.
      load_tile(0, 1, 0, 0);
      run_job(0, 5);
      full_job(jobs[0], "post_rst");

`ifdef ARRAY_FEEDER_PERF_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("perf_zero_start", 64'(perf_cycles), 64'd0);
      full_job(jobs[1], "perf_a");
      full_job(jobs[0], "perf_b");
      chk("perf_two_jobs", 64'(perf_cycles), 64'd24);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("perf_rst", 64'(perf_cycles), 64'd0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
